// File: rtl/ece2300_stream_checker_pkg.sv
// Shared types and constants for the stream checker: FSM state encoding and
// LFSR seed/taps used by the optional random-stall path.
package ece2300_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hBEEF;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ece2300_stream_checker_lfsr16.sv
// 16-bit Galois LFSR; reseeds on rst or load, advances when en is high.
module ece2300_lfsr16
    import ece2300_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/ece2300_stream_checker.sv
// Stream checker: compares incoming messages against a preloaded expected list.
// Optional random back-pressure on in_rdy when ECE2300_STREAM_CHECKER_RAND_STALL_EN is defined.
module ece2300_stream_checker
    import ece2300_test_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 10000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [NBITS-1:0]           load_data,
    input  logic [$clog2(DEPTH):0]     num_msgs,
    input  logic                       start,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [NBITS-1:0]           in_msg,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [15:0]                err_count,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx,
    output logic [31:0]                cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t               state, state_n;
    logic [NBITS-1:0]     mem [DEPTH];
    logic [AW-1:0]        idx;
    logic [CW-1:0]        num_r;
    logic                 start_ok;
    logic                 xfer;
    logic                 last;
    logic                 mismatch;
    logic                 tmo_hit;
    logic                 run_rdy;

    assign start_ok = start && (state != RUN);
    assign xfer     = in_val && in_rdy;
    assign last     = ({1'b0, idx} == (num_r - CW'(1)));
    assign mismatch = (in_msg !== mem[idx]);
    assign tmo_hit  = (cycles == 32'(TIMEOUT - 1));

`ifdef ECE2300_STREAM_CHECKER_RAND_STALL_EN
    logic [15:0] lfsr_q;

    ece2300_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (state == RUN),
        .q    (lfsr_q)
    );

    assign run_rdy = (lfsr_q[1:0] != 2'b00);
`else
    assign run_rdy = 1'b1;
`endif

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign in_rdy  = busy && run_rdy;
    assign pass    = done && (err_count == 16'h0000) && !timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (num_msgs == '0 || num_msgs > CW'(DEPTH)) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if ((xfer && last) || tmo_hit) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Expected memory is deliberately outside reset so it survives an aborted run.
    always_ff @(posedge clk) begin
        if (!rst && load_en && state != RUN) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            num_r         <= '0;
            err_count     <= 16'h0000;
            first_err_idx <= '0;
            cycles        <= 32'h0;
            timeout       <= 1'b0;
        end else if (start_ok) begin
            idx           <= '0;
            num_r         <= num_msgs;
            err_count     <= (num_msgs > CW'(DEPTH)) ? 16'h0001 : 16'h0000;
            first_err_idx <= '0;
            cycles        <= 32'h0;
            timeout       <= 1'b0;
        end else if (state == RUN) begin
            cycles <= cycles + 32'h1;
            if (xfer) begin
                idx <= idx + AW'(1);
                if (mismatch) begin
                    if (err_count == 16'h0000) begin
                        first_err_idx <= idx;
                    end
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'h1;
                    end
                end
            end
            // A final transfer landing on the timeout cycle completes normally.
            if (tmo_hit && !(xfer && last)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ece2300_stream_checker.sv
// Scoreboard bench for ece2300_stream_checker: expected run results are queued
// at launch and compared when the checker reports done.
module tb_ece2300_stream_checker;
    import ece2300_test_pkg::*;

`ifdef ECE2300_STREAM_CHECKER_RAND_STALL_EN
    localparam int TMO = 200;
    localparam bit EXACT_CYC = 1'b0;
`else
    localparam int TMO = 20;
    localparam bit EXACT_CYC = 1'b1;
`endif
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  num_msgs;
    logic        start;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [3:0]  first_err_idx;
    logic [31:0] cycles;

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [3:0]  fidx;
        logic        to;
        logic [31:0] cyc;
        bit          exact;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] feed [32];
    int          n_vec = 0;
    int          n_mis = 0;
    int          rdy_bad = 0;

    ece2300_stream_checker #(.NBITS(32), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .num_msgs(num_msgs), .start(start),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_idx(first_err_idx), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en = 1'b1; load_addr = 4'(a); load_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic drive_cycle(input logic v, input logic [31:0] m, output logic x);
        in_val = v; in_msg = m;
        @(negedge clk);
        if (in_rdy && !busy) rdy_bad++;
        x = v && in_rdy;
        @(posedge clk); #1;
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
        chk({tag, "_err"}, 32'(err_count), 32'(e.err));
        chk({tag, "_fidx"}, 32'(first_err_idx), 32'(e.fidx));
        chk({tag, "_tmo"}, 32'(timeout), 32'(e.to));
        if (e.exact) chk({tag, "_cycles"}, cycles, e.cyc);
        else         chk({tag, "_cycles_min"}, 32'(cycles >= e.cyc), 32'd1);
    endtask

    task automatic start_run(input int n);
        num_msgs = 5'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_check(input int n, input int nfeed, input bit poke);
        exp_t e;
        exp_t got;
        int k, cyc;
        logic x;
        e.err = 16'h0; e.fidx = 4'h0; e.to = 1'b0; e.cyc = 32'h0; e.exact = 1'b1;
        if (n > DEPTH) begin
            e.err = 16'h1;
        end else if (n > 0) begin
            for (int i = 0; i < n && i < nfeed; i++) begin
                if (feed[i] !== ref_mem[i]) begin
                    if (e.err == 0) e.fidx = 4'(i);
                    e.err++;
                end
            end
            if (nfeed < n) begin
                e.to = 1'b1; e.cyc = 32'(TMO);
            end else begin
                e.cyc = 32'(n); e.exact = EXACT_CYC;
            end
        end
        e.pass = (e.err == 0) && !e.to;
        sb.push_back(e);
        start_run(n);
        k = 0; cyc = 0;
        while (!done && cyc < 400) begin
            if (poke && cyc == 1) begin
                load_en = 1'b1; load_addr = 4'h0; load_data = 32'hDEAD_0000;
            end
            drive_cycle(k < nfeed, feed[k % 32], x);
            load_en = 1'b0;
            if (x) k++;
            cyc++;
        end
        in_val = 1'b0;
        chk("done_reached", 32'(done), 32'd1);
        got = sb.pop_front();
        check_result("res", got);
        repeat (3) drive_cycle(1'b1, 32'h5A5A_5A5A, x);
        in_val = 1'b0;
        check_result("hold", got);
    endtask

    initial begin
        logic x;
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        num_msgs = '0; start = 1'b0; in_val = 1'b0; in_msg = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hx;
        for (int i = 0; i < 32; i++) feed[i] = 32'h0;
        do_reset();
        @(negedge clk);
        chk("rst_rdy", 32'(in_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_tmo", 32'(timeout), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_fidx", 32'(first_err_idx), 0);
        chk("rst_cycles", cycles, 0);
        @(posedge clk); #1;

        load(0, 32'h11); load(1, 32'h22); load(2, 32'h33);

        feed[0] = 32'h11; feed[1] = 32'h22; feed[2] = 32'h33;
        run_check(3, 3, 1'b0);

        feed[1] = 32'hFF;
        run_check(3, 3, 1'b0);

        feed[1] = 32'h22;
        run_check(2, 1, 1'b0);

        run_check(0, 0, 1'b0);
        chk("zero_rdy", 32'(in_rdy), 0);

        run_check(17, 0, 1'b0);

        // abort after one transfer, memory must survive the reset
        start_run(3);
        while (!busy) @(posedge clk);
        #1;
        for (int g = 0; g < 50; g++) begin
            drive_cycle(1'b1, feed[0], x);
            if (x) break;
        end
        in_val = 1'b0;
        do_reset();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_cycles", cycles, 0);
        @(posedge clk); #1;
        run_check(3, 3, 1'b1);  // load_en during RUN must be ignored
        run_check(3, 3, 1'b0);

        for (int i = 0; i < DEPTH; i++) load(i, $urandom());
        for (int i = 0; i < DEPTH; i++) feed[i] = ref_mem[i];
        run_check(16, 16, 1'b0);
        feed[5] = ~feed[5]; feed[9] = feed[9] ^ 32'h100;
        run_check(16, 16, 1'b0);

        // reset wins over start in the same cycle
        num_msgs = 5'd3; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_pri_busy", 32'(busy), 0);
        chk("rst_pri_done", 32'(done), 0);

        chk("rdy_outside_run", 32'(rdy_bad), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
